// File: rtl/arm_decode_stage.sv
// Decode stage: 32 x N register file with same-cycle write bypass and an
// immediate extractor for LDUR/STUR, CBZ, MOVZ and ADDI/SUBI encodings.
module arm_decode_stage #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         regWrite_D,
    input  logic         reg2loc_D,
    input  logic [4:0]   wa3_D,
    input  logic [N-1:0] writeData3_D,
    input  logic [31:0]  instr_D,
    output logic [N-1:0] readData1_D,
    output logic [N-1:0] readData2_D,
    output logic [N-1:0] signImm_D
);

    localparam int unsigned NREGS = 32;
    localparam logic [4:0]  XZR   = 5'd31;

    logic [N-1:0] regs [NREGS];
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic         bypass_en;

    assign ra1       = instr_D[9:5];
    assign ra2       = reg2loc_D ? instr_D[4:0] : instr_D[20:16];
    assign bypass_en = regWrite_D && !reset;

    // Reset loads Xi = i; the XZR slot is kept at zero and never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= (i == int'(XZR)) ? '0 : N'(i);
            end
        end else if (regWrite_D && (wa3_D != XZR)) begin
            regs[wa3_D] <= writeData3_D;
        end
    end

    // Read ports: XZR first, then write-before-read bypass, then storage.
    always_comb begin
        readData1_D = regs[ra1];
        readData2_D = regs[ra2];
        if (ra1 == XZR) begin
            readData1_D = '0;
        end else if (bypass_en && (wa3_D == ra1)) begin
            readData1_D = writeData3_D;
        end
        if (ra2 == XZR) begin
            readData2_D = '0;
        end else if (bypass_en && (wa3_D == ra2)) begin
            readData2_D = writeData3_D;
        end
    end

    logic [N-1:0] movz_base;
    logic [5:0]   movz_shift;

    assign movz_base  = N'(instr_D[20:5]);
    assign movz_shift = {instr_D[22:21], 4'b0000};

    // Immediate decode in priority order; unknown encodings yield zero.
    always_comb begin
        signImm_D = '0;
        if ((instr_D[31:21] == 11'b11111000010) || (instr_D[31:21] == 11'b11111000000)) begin
            signImm_D = {{(N-9){instr_D[20]}}, instr_D[20:12]};
        end else if (instr_D[31:24] == 8'b10110100) begin
            signImm_D = {{(N-19){instr_D[23]}}, instr_D[23:5]};
        end else if (instr_D[31:23] == 9'b110100101) begin
            signImm_D = movz_base << movz_shift;
        end else if ((instr_D[31:22] == 10'b1001000100) || (instr_D[31:22] == 10'b1101000100)) begin
            signImm_D = N'(instr_D[21:10]);
        end
    end

endmodule

// File: tb/tb_arm_decode_stage.sv
// Scoreboard bench for arm_decode_stage: directed register/immediate cases
// followed by randomized traffic against an arithmetic reference model.
module tb_arm_decode_stage;

    logic        clk;
    logic        reset;
    logic        regWrite_D;
    logic        reg2loc_D;
    logic [4:0]  wa3_D;
    logic [63:0] writeData3_D;
    logic [31:0] instr_D;
    logic [63:0] readData1_D;
    logic [63:0] readData2_D;
    logic [63:0] signImm_D;

    arm_decode_stage #(.N(64)) dut (
        .clk(clk),
        .reset(reset),
        .regWrite_D(regWrite_D),
        .reg2loc_D(reg2loc_D),
        .wa3_D(wa3_D),
        .writeData3_D(writeData3_D),
        .instr_D(instr_D),
        .readData1_D(readData1_D),
        .readData2_D(readData2_D),
        .signImm_D(signImm_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
    } exp_t;

    exp_t        sb[$];
    longint      model[32];
    int          checks;
    int          errors;
    int          tag_cnt;

    // Reference model state lookup with XZR and same-cycle write visibility.
    function automatic longint model_read(input int a, input bit rst, input bit we,
                                          input int wa, input longint wd);
        if (a == 31) return 0;
        if (we && !rst && wa == a) return wd;
        return model[a];
    endfunction

    function automatic longint sext(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half * 2) : v;
    endfunction

    function automatic longint model_imm(input logic [31:0] ins);
        int op11, op8, op9, op10;
        op11 = int'(ins >> 21);
        op8  = int'(ins >> 24);
        op9  = int'(ins >> 23);
        op10 = int'(ins >> 22);
        if (op11 == 'h7C2 || op11 == 'h7C0) return sext(longint'((ins >> 12) % 512), 9);
        if (op8 == 'hB4) return sext(longint'((ins >> 5) % (1 << 19)), 19);
        if (op9 == 'h1A5) return longint'((ins >> 5) % 65536) * (longint'(1) << (16 * ((ins >> 21) % 4)));
        if (op10 == 'h244 || op10 == 'h344) return longint'((ins >> 10) % 4096);
        return 0;
    endfunction

    function automatic logic [31:0] mk_ldur(input int imm9, input int rn, input int rt);
        return {11'b11111000010, 9'(imm9), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] mk_stur(input int imm9, input int rn, input int rt);
        return {11'b11111000000, 9'(imm9), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] mk_cbz(input int imm19, input int rt);
        return {8'b10110100, 19'(imm19), 5'(rt)};
    endfunction
    function automatic logic [31:0] mk_movz(input int hw, input int imm16, input int rd);
        return {9'b110100101, 2'(hw), 16'(imm16), 5'(rd)};
    endfunction
    function automatic logic [31:0] mk_addi(input bit sub, input int imm12, input int rn, input int rd);
        return {sub ? 10'b1101000100 : 10'b1001000100, 12'(imm12), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] mk_rr(input int rm, input int rn, input int rd);
        return {11'b0, 5'(rm), 6'b0, 5'(rn), 5'(rd)};
    endfunction

    // Drive one cycle just after a rising edge; expected values go to the scoreboard.
    task automatic apply(input bit chk, input bit rst, input bit we, input bit r2l,
                         input int wa, input logic [63:0] wd, input logic [31:0] ins);
        exp_t e;
        int   a1, a2;
        reset        = rst;
        regWrite_D   = we;
        reg2loc_D    = r2l;
        wa3_D        = 5'(wa);
        writeData3_D = wd;
        instr_D      = ins;
        a1 = int'(ins[9:5]);
        a2 = r2l ? int'(ins[4:0]) : int'(ins[20:16]);
        if (chk) begin
            tag_cnt++;
            e.tag = tag_cnt;
            e.rd1 = model_read(a1, rst, we, wa, longint'(wd));
            e.rd2 = model_read(a2, rst, we, wa, longint'(wd));
            e.imm = model_imm(ins);
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = (i == 31) ? 0 : longint'(i);
        end else if (we && wa != 31) begin
            model[wa] = longint'(wd);
        end
        #1;
    endtask

    // Monitor: outputs are combinational, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks += 3;
            if (readData1_D !== e.rd1) begin
                errors++;
                $display("FAIL rd1 #%0d: got %h expected %h", e.tag, readData1_D, e.rd1);
            end
            if (readData2_D !== e.rd2) begin
                errors++;
                $display("FAIL rd2 #%0d: got %h expected %h", e.tag, readData2_D, e.rd2);
            end
            if (signImm_D !== e.imm) begin
                errors++;
                $display("FAIL imm #%0d: got %h expected %h", e.tag, signImm_D, e.imm);
            end
        end
    end

    logic [31:0] ins_r;
    int          kind;

    initial begin
        checks  = 0;
        errors  = 0;
        tag_cnt = 0;
        reset = 1'b0; regWrite_D = 1'b0; reg2loc_D = 1'b0;
        wa3_D = '0; writeData3_D = '0; instr_D = '0;
        @(posedge clk); #1;

        // Initial reset, then reset contents on both ports.
        apply(0, 1, 0, 0, 0, 64'd0, 32'd0);
        apply(1, 0, 0, 0, 0, 64'd0, mk_rr(30, 5, 0));
        apply(1, 0, 0, 1, 0, 64'd0, mk_rr(0, 0, 17));

        // Bypass of a write to X7, then the stored value.
        apply(1, 0, 1, 0, 7, 64'hDEAD, mk_rr(2, 7, 0));
        apply(1, 0, 0, 0, 0, 64'd0, mk_rr(7, 7, 0));
        // Both ports bypassing the same write.
        apply(1, 0, 1, 1, 12, 64'h0123_4567_89AB_CDEF, mk_rr(0, 12, 12));

        // XZR: write ignored, reads zero on both ports.
        apply(1, 0, 1, 0, 31, 64'h1234, mk_rr(31, 31, 31));
        apply(1, 0, 0, 1, 0, 64'd0, mk_rr(0, 31, 31));

        // Read-address mux after reset.
        apply(1, 1, 0, 0, 0, 64'd0, 32'd0);
        apply(1, 0, 0, 0, 0, 64'd0, mk_rr(9, 1, 3));
        apply(1, 0, 0, 1, 0, 64'd0, mk_rr(9, 1, 3));

        // Immediate encodings.
        apply(1, 0, 0, 0, 0, 64'd0, mk_ldur('h1FF, 2, 3));
        apply(1, 0, 0, 0, 0, 64'd0, mk_stur('h0FF, 4, 5));
        apply(1, 0, 0, 0, 0, 64'd0, mk_cbz('h00004, 6));
        apply(1, 0, 0, 0, 0, 64'd0, mk_cbz('h40000, 6));
        apply(1, 0, 0, 0, 0, 64'd0, mk_movz(2, 'hBEEF, 1));
        apply(1, 0, 0, 0, 0, 64'd0, mk_movz(3, 'h8001, 1));
        apply(1, 0, 0, 0, 0, 64'd0, mk_addi(0, 'hFFF, 8, 9));
        apply(1, 0, 0, 0, 0, 64'd0, mk_addi(1, 'h123, 8, 9));
        apply(1, 0, 0, 0, 0, 64'd0, 32'd0);

        // Reset priority over a write and suppression of bypass during reset.
        apply(1, 0, 1, 0, 4, 64'd77, mk_rr(0, 10, 0));
        apply(1, 1, 1, 0, 4, 64'd99, mk_rr(0, 4, 4));
        apply(1, 0, 0, 0, 0, 64'd0, mk_rr(4, 4, 0));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: ins_r = mk_ldur(int'($urandom), int'($urandom), int'($urandom));
                1: ins_r = mk_cbz(int'($urandom), int'($urandom));
                2: ins_r = mk_movz(int'($urandom), int'($urandom), int'($urandom));
                3: ins_r = mk_addi(1'($urandom), int'($urandom), int'($urandom), int'($urandom));
                default: ins_r = $urandom;
            endcase
            apply(1, ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 31)),
                  {$urandom, $urandom}, ins_r);
        end

        apply(0, 0, 0, 0, 0, 64'd0, 32'd0);
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
